// File: rtl/carbon_arch_pkg.sv
// Shared Z480 architecture constants: CPUID leaf indices, vendor string words,
// and the enumerator state/error encodings used by requester and responder.
package carbon_arch_pkg;

    localparam logic [31:0] CARBON_CPUID_LEAF_VENDOR    = 32'd0;
    localparam logic [31:0] CARBON_CPUID_LEAF_ID        = 32'd1;
    localparam logic [31:0] CARBON_CPUID_LEAF_TIERS     = 32'd2;
    localparam logic [31:0] CARBON_CPUID_LEAF_FEATURES0 = 32'd3;
    localparam logic [31:0] CARBON_CPUID_LEAF_TOPOLOGY  = 32'd4;

    localparam logic [15:0] CARBON_CPUID_FMT_VERSION = 16'd1;

    // "CARB", "ON-Z", "480 " with the first character in the most significant byte
    localparam logic [31:0] CARBON_Z480_VENDOR_W1 = 32'h4341_5242;
    localparam logic [31:0] CARBON_Z480_VENDOR_W2 = 32'h4F4E_2D5A;
    localparam logic [31:0] CARBON_Z480_VENDOR_W3 = 32'h3438_3020;

    typedef enum logic [2:0] {
        ENUM_IDLE = 3'd0,
        ENUM_REQ  = 3'd1,
        ENUM_WAIT = 3'd2,
        ENUM_NEXT = 3'd3,
        ENUM_DONE = 3'd4,
        ENUM_ERR  = 3'd5
    } cpuid_enum_state_e;

    typedef enum logic [1:0] {
        CPUID_ERR_NONE    = 2'd0,
        CPUID_ERR_TIMEOUT = 2'd1,
        CPUID_ERR_FORMAT  = 2'd2,
        CPUID_ERR_VENDOR  = 2'd3
    } cpuid_enum_err_e;

    function automatic logic [15:0] clamp_leaf(input logic [15:0] reported,
                                               input logic [31:0] limit);
        if ({16'h0, reported} > limit) begin
            return limit[15:0];
        end
        return reported;
    endfunction

endpackage

// File: rtl/cpuid_enumerator.sv
// Boot-time CPUID requester: walks the standard leaves over the CSR-window
// transport and latches a discovery snapshot for firmware and the boot sequencer.
module cpuid_enumerator
    import carbon_arch_pkg::*;
#(
    parameter int MAX_LEAF_LIMIT = 16,
    parameter int RSP_TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_leaf,
    output logic [31:0] req_subleaf,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    input  logic [63:0] rsp_data0,
    input  logic [63:0] rsp_data1,
    input  logic [63:0] rsp_data2,
    input  logic [63:0] rsp_data3,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [15:0] max_leaf,
    output logic [31:0] id_word,
    output logic [31:0] chip_flags,
    output logic [31:0] cpu_tier,
    output logic [31:0] fpu_tier,
    output logic [31:0] features0,
    output logic [15:0] core_count,
    output logic [15:0] threads_per_core,
    output logic [15:0] vector_bits,
    output logic [15:0] arch_bits,
    output logic [2:0]  fsm_state
);

    localparam int TW = $clog2(RSP_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(RSP_TIMEOUT - 1);

    cpuid_enum_state_e state;
    cpuid_enum_err_e   err_q;
    logic [31:0]       leaf_cnt;
    logic [TW-1:0]     tmo_cnt;

    logic [31:0] w0, w1, w2, w3;
    logic        unused_hi;

    // Transport lanes are 64 bits wide but v1 responses carry data in [31:0] only.
    assign w0 = rsp_data0[31:0];
    assign w1 = rsp_data1[31:0];
    assign w2 = rsp_data2[31:0];
    assign w3 = rsp_data3[31:0];
    assign unused_hi = ^{rsp_data0[63:32], rsp_data1[63:32], rsp_data2[63:32], rsp_data3[63:32]};

    assign req_leaf    = leaf_cnt;
    assign req_subleaf = 32'h0;
    assign err_code    = err_q;
    assign fsm_state   = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ENUM_IDLE;
            err_q            <= CPUID_ERR_NONE;
            leaf_cnt         <= 32'h0;
            tmo_cnt          <= '0;
            req_valid        <= 1'b0;
            rsp_ready        <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
            max_leaf         <= 16'h0;
            id_word          <= 32'h0;
            chip_flags       <= 32'h0;
            cpu_tier         <= 32'h0;
            fpu_tier         <= 32'h0;
            features0        <= 32'h0;
            core_count       <= 16'h0;
            threads_per_core <= 16'h0;
            vector_bits      <= 16'h0;
            arch_bits        <= 16'h0;
        end else begin
            case (state)
                ENUM_IDLE: begin
                    if (start) begin
                        err_q            <= CPUID_ERR_NONE;
                        done             <= 1'b0;
                        error            <= 1'b0;
                        max_leaf         <= 16'h0;
                        id_word          <= 32'h0;
                        chip_flags       <= 32'h0;
                        cpu_tier         <= 32'h0;
                        fpu_tier         <= 32'h0;
                        features0        <= 32'h0;
                        core_count       <= 16'h0;
                        threads_per_core <= 16'h0;
                        vector_bits      <= 16'h0;
                        arch_bits        <= 16'h0;
                        leaf_cnt         <= CARBON_CPUID_LEAF_VENDOR;
                        req_valid        <= 1'b1;
                        busy             <= 1'b1;
                        state            <= ENUM_REQ;
                    end
                end

                // req_valid/req_leaf are held untouched until the responder takes them.
                ENUM_REQ: begin
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        rsp_ready <= 1'b1;
                        tmo_cnt   <= '0;
                        state     <= ENUM_WAIT;
                    end
                end

                ENUM_WAIT: begin
                    if (rsp_valid) begin
                        rsp_ready <= 1'b0;
                        state     <= ENUM_NEXT;
                        case (leaf_cnt)
                            CARBON_CPUID_LEAF_VENDOR: begin
                                if (w0[31:16] != CARBON_CPUID_FMT_VERSION) begin
                                    err_q <= CPUID_ERR_FORMAT;
                                    state <= ENUM_ERR;
                                end else if (w1 != CARBON_Z480_VENDOR_W1 ||
                                             w2 != CARBON_Z480_VENDOR_W2 ||
                                             w3 != CARBON_Z480_VENDOR_W3) begin
                                    err_q <= CPUID_ERR_VENDOR;
                                    state <= ENUM_ERR;
                                end else begin
                                    max_leaf <= clamp_leaf(w0[15:0], 32'(MAX_LEAF_LIMIT));
                                end
                            end
                            CARBON_CPUID_LEAF_ID: begin
                                id_word    <= w0;
                                chip_flags <= w1;
                            end
                            CARBON_CPUID_LEAF_TIERS: begin
                                cpu_tier <= w0;
                                fpu_tier <= w1;
                            end
                            CARBON_CPUID_LEAF_FEATURES0: begin
                                features0 <= w0;
                            end
                            CARBON_CPUID_LEAF_TOPOLOGY: begin
                                core_count       <= w0[15:0];
                                threads_per_core <= w0[31:16];
                                vector_bits      <= w1[15:0];
                                arch_bits        <= w1[31:16];
                            end
                            default: ;
                        endcase
                    end else if (tmo_cnt == TMO_LAST) begin
                        rsp_ready <= 1'b0;
                        err_q     <= CPUID_ERR_TIMEOUT;
                        state     <= ENUM_ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                ENUM_NEXT: begin
                    if (leaf_cnt >= {16'h0, max_leaf}) begin
                        state <= ENUM_DONE;
                    end else begin
                        leaf_cnt  <= leaf_cnt + 32'd1;
                        req_valid <= 1'b1;
                        state     <= ENUM_REQ;
                    end
                end

                ENUM_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ENUM_IDLE;
                end

                ENUM_ERR: begin
                    error <= 1'b1;
                    busy  <= 1'b0;
                    state <= ENUM_IDLE;
                end

                default: begin
                    req_valid <= 1'b0;
                    rsp_ready <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ENUM_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpuid_enumerator.sv
// Bench for cpuid_enumerator: table of whole walks against a scripted responder,
// plus hand-written reset-in-WAIT and restart sequences.
module tb_cpuid_enumerator;

    localparam logic [31:0] NONE     = 32'hFFFF_FFFF;
    localparam logic [31:0] VEN_CARB = 32'h4341_5242;
    localparam logic [31:0] VEN_XARB = 32'h5841_5242;
    localparam logic [31:0] VEN_ONZ  = 32'h4F4E_2D5A;
    localparam logic [31:0] VEN_480  = 32'h3438_3020;
    localparam logic [31:0] ID_W0    = 32'h0480_0001;
    localparam logic [31:0] ID_W1    = 32'h0000_00A5;
    localparam logic [31:0] TIER_W0  = 32'h0000_0003;
    localparam logic [31:0] FEAT_W0  = 32'h8000_00F1;
    localparam logic [31:0] TOPO_W0  = 32'h0001_0002;
    localparam logic [31:0] TOPO_W1  = 32'h0040_0080;
    localparam logic [63:0] TOPO_EXP = {16'd2, 16'd1, 16'd128, 16'd64};

    logic        clk = 0;
    logic        rst;
    logic        start;
    logic        req_valid, req_ready;
    logic [31:0] req_leaf, req_subleaf;
    logic        rsp_valid, rsp_ready;
    logic [63:0] rsp_data0, rsp_data1, rsp_data2, rsp_data3;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [15:0] max_leaf;
    logic [31:0] id_word, chip_flags, cpu_tier, fpu_tier, features0;
    logic [15:0] core_count, threads_per_core, vector_bits, arch_bits;
    logic [2:0]  fsm_state;

    cpuid_enumerator dut (
        .clk(clk), .rst(rst), .start(start),
        .req_valid(req_valid), .req_ready(req_ready), .req_leaf(req_leaf), .req_subleaf(req_subleaf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data0(rsp_data0), .rsp_data1(rsp_data1), .rsp_data2(rsp_data2), .rsp_data3(rsp_data3),
        .busy(busy), .done(done), .error(error), .err_code(err_code), .max_leaf(max_leaf),
        .id_word(id_word), .chip_flags(chip_flags), .cpu_tier(cpu_tier), .fpu_tier(fpu_tier),
        .features0(features0), .core_count(core_count), .threads_per_core(threads_per_core),
        .vector_bits(vector_bits), .arch_bits(arch_bits), .fsm_state(fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- responder model ----------------
    logic [31:0] ven_w0;
    bit          bad_vendor;
    logic [31:0] noans_leaf;
    logic [31:0] bp_leaf;
    int          bp_left;
    bit          bp_seen;
    bit          rsp_pending;
    logic [31:0] rsp_leaf;
    int          hs_count;
    int          busy_cnt;
    int          rspr_cnt;

    task automatic load_rsp(input logic [31:0] leaf);
        rsp_data0 = {$urandom, $urandom};
        rsp_data1 = {$urandom, $urandom};
        rsp_data2 = {$urandom, $urandom};
        rsp_data3 = {$urandom, $urandom};
        case (leaf)
            32'd0: begin
                rsp_data0[31:0] = ven_w0;
                rsp_data1[31:0] = bad_vendor ? VEN_XARB : VEN_CARB;
                rsp_data2[31:0] = VEN_ONZ;
                rsp_data3[31:0] = VEN_480;
            end
            32'd1: begin rsp_data0[31:0] = ID_W0;   rsp_data1[31:0] = ID_W1; end
            32'd2: begin rsp_data0[31:0] = TIER_W0; rsp_data1[31:0] = 32'd2; end
            32'd3: rsp_data0[31:0] = FEAT_W0;
            32'd4: begin rsp_data0[31:0] = TOPO_W0; rsp_data1[31:0] = TOPO_W1; end
            default: ;
        endcase
    endtask

    initial begin
        req_ready = 0; rsp_valid = 0; rsp_pending = 0; rsp_leaf = 0; hs_count = 0;
        rsp_data0 = 0; rsp_data1 = 0; rsp_data2 = 0; rsp_data3 = 0;
        forever begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (rsp_ready) rspr_cnt++;
            rsp_valid = 0;
            if (rsp_pending && rsp_ready && rsp_leaf != noans_leaf) begin
                load_rsp(rsp_leaf);
                rsp_valid = 1;
                rsp_pending = 0;
            end
            if (bp_seen && bp_left > 0) begin
                check("bp_req_valid_held", {63'h0, req_valid}, 64'h1);
                check("bp_req_leaf_held", {32'h0, req_leaf}, {32'h0, bp_leaf});
                req_ready = 0;
                bp_left--;
            end else if (req_valid && req_leaf == bp_leaf && bp_left > 0) begin
                bp_seen = 1;
                req_ready = 0;
                bp_left--;
            end else if (req_valid && !rst) begin
                // Handshake happens at the coming posedge.
                req_ready = 1;
                hs_count++;
                if (exp_q.size() == 0) begin
                    check("req_extra", {32'h0, req_leaf}, 64'hFFFF_FFFF);
                end else begin
                    check("req_leaf", {32'h0, req_leaf}, {32'h0, exp_q.pop_front()});
                end
                check("req_subleaf", {32'h0, req_subleaf}, 64'h0);
                rsp_pending = 1;
                rsp_leaf = req_leaf;
            end else begin
                req_ready = 0;
            end
        end
    end

    // ---------------- walk vectors ----------------
    typedef struct {
        logic [31:0] ven_w0;
        bit          bad_vendor;
        logic [31:0] noans;
        logic [31:0] bp_leaf;
        int          bp_cycles;
        bit          restart;
        bit          exp_done;
        logic [1:0]  exp_code;
        logic [15:0] exp_max;
        int          exp_reqs;
        int          exp_busy;
        int          exp_rspr;
        logic [31:0] exp_id;
        logic [63:0] exp_topo;
        logic [31:0] exp_feat;
    } vec_t;

    vec_t vecs[8];

    task automatic run_walk(input int vi);
        vec_t v;
        bit   fin;
        bit   restarted;
        v = vecs[vi];
        @(negedge clk);
        ven_w0 = v.ven_w0; bad_vendor = v.bad_vendor; noans_leaf = v.noans;
        bp_leaf = v.bp_leaf; bp_left = v.bp_cycles; bp_seen = 0;
        hs_count = 0; busy_cnt = 0; rspr_cnt = 0;
        exp_q.delete();
        for (int i = 0; i < v.exp_reqs; i++) exp_q.push_back(32'(i));
        start = 1;
        fin = 0;
        restarted = 0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            @(negedge clk);
            start = 0;
            if (cyc == 0) check($sformatf("v%0d_start_to_req_valid", vi), {63'h0, req_valid}, 64'h1);
            if (v.restart && !restarted && hs_count == 2) begin
                start = 1;
                restarted = 1;
            end
            if (done || error) fin = 1;
        end
        start = 0;
        check($sformatf("v%0d_finished", vi), {63'h0, fin}, 64'h1);
        check($sformatf("v%0d_done", vi), {63'h0, done}, {63'h0, v.exp_done});
        check($sformatf("v%0d_error", vi), {63'h0, error}, {63'h0, !v.exp_done});
        check($sformatf("v%0d_err_code", vi), {62'h0, err_code}, {62'h0, v.exp_code});
        check($sformatf("v%0d_max_leaf", vi), {48'h0, max_leaf}, {48'h0, v.exp_max});
        check($sformatf("v%0d_req_count", vi), 64'(hs_count), 64'(v.exp_reqs));
        check($sformatf("v%0d_exp_q_empty", vi), 64'(exp_q.size()), 64'h0);
        check($sformatf("v%0d_busy_cycles", vi), 64'(busy_cnt), 64'(v.exp_busy));
        check($sformatf("v%0d_wait_cycles", vi), 64'(rspr_cnt), 64'(v.exp_rspr));
        check($sformatf("v%0d_id_word", vi), {32'h0, id_word}, {32'h0, v.exp_id});
        check($sformatf("v%0d_chip_flags", vi), {32'h0, chip_flags},
              {32'h0, (v.exp_id != 0) ? ID_W1 : 32'h0});
        check($sformatf("v%0d_cpu_tier", vi), {32'h0, cpu_tier},
              {32'h0, (v.exp_feat != 0) ? TIER_W0 : 32'h0});
        check($sformatf("v%0d_topology", vi), {core_count, threads_per_core, vector_bits, arch_bits},
              v.exp_topo);
        check($sformatf("v%0d_features0", vi), {32'h0, features0}, {32'h0, v.exp_feat});
        check($sformatf("v%0d_busy_low", vi), {63'h0, busy}, 64'h0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_valid"}, {63'h0, req_valid}, 64'h0);
        check({tag, "_rsp_ready"}, {63'h0, rsp_ready}, 64'h0);
        check({tag, "_busy"}, {63'h0, busy}, 64'h0);
        check({tag, "_done_error"}, {62'h0, done, error}, 64'h0);
        check({tag, "_err_code"}, {62'h0, err_code}, 64'h0);
        check({tag, "_max_leaf"}, {48'h0, max_leaf}, 64'h0);
        check({tag, "_req_leaf"}, {32'h0, req_leaf}, 64'h0);
        check({tag, "_id_chip"}, {id_word, chip_flags}, 64'h0);
        check({tag, "_tiers"}, {cpu_tier, fpu_tier}, 64'h0);
        check({tag, "_features0"}, {32'h0, features0}, 64'h0);
        check({tag, "_topology"}, {core_count, threads_per_core, vector_bits, arch_bits}, 64'h0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        //        ven_w0         bad noans bp_leaf bp rst done code max reqs busy rspr id     topo      feat
        vecs[0] = '{32'h0001_0004, 0, NONE, NONE,  0, 0, 1, 2'd0, 16'd4,  5, 16,  5, ID_W0, TOPO_EXP, FEAT_W0};
        vecs[1] = '{32'h0001_0004, 0, NONE, 32'd2, 7, 0, 1, 2'd0, 16'd4,  5, 23,  5, ID_W0, TOPO_EXP, FEAT_W0};
        vecs[2] = '{32'h0002_0004, 0, NONE, NONE,  0, 0, 0, 2'd2, 16'd0,  1,  3,  1, 32'h0, 64'h0,    32'h0};
        vecs[3] = '{32'h0001_0004, 1, NONE, NONE,  0, 0, 0, 2'd3, 16'd0,  1,  3,  1, 32'h0, 64'h0,    32'h0};
        vecs[4] = '{32'h0001_00FF, 0, NONE, NONE,  0, 0, 1, 2'd0, 16'd16, 17, 52, 17, ID_W0, TOPO_EXP, FEAT_W0};
        vecs[5] = '{32'h0001_0004, 0, 32'd1, NONE, 0, 0, 0, 2'd1, 16'd4,  2, 69, 65, 32'h0, 64'h0,    32'h0};
        vecs[6] = '{32'h0001_0000, 0, NONE, NONE,  0, 0, 1, 2'd0, 16'd0,  1,  4,  1, 32'h0, 64'h0,    32'h0};
        vecs[7] = '{32'h0001_0004, 0, NONE, NONE,  0, 1, 1, 2'd0, 16'd4,  5, 16,  5, ID_W0, TOPO_EXP, FEAT_W0};

        ven_w0 = 32'h0001_0004; bad_vendor = 0; noans_leaf = NONE; bp_leaf = NONE;
        bp_left = 0; bp_seen = 0; busy_cnt = 0; rspr_cnt = 0;
        rst = 1; start = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        check_all_zero("reset");

        for (int i = 0; i < 8; i++) run_walk(i);

        // Reset while waiting on a response that never arrives.
        @(negedge clk);
        ven_w0 = 32'h0001_0004; bad_vendor = 0; noans_leaf = 32'd1; bp_leaf = NONE; bp_left = 0;
        hs_count = 0;
        exp_q.delete();
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        start = 1;
        @(negedge clk);
        start = 0;
        for (int cyc = 0; cyc < 50 && hs_count < 2; cyc++) @(negedge clk);
        @(negedge clk);
        check("rstwait_in_wait", {63'h0, rsp_ready}, 64'h1);
        check("rstwait_max_leaf_before", {48'h0, max_leaf}, 64'd4);
        rst = 1;
        @(negedge clk);
        check_all_zero("rstwait");
        rst = 0;
        check("rstwait_exp_q_empty", 64'(exp_q.size()), 64'h0);

        // Fresh walk after the mid-walk reset.
        run_walk(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
